// File: rtl/ldl_cdc_hs_src.sv
// ldl_cdc_hs_src: source side of a 4-phase req/ack clock-domain-crossing handshake.
// A word is accepted via valid/ready and held on xdata. A level req is raised and
// kept until the synchronized ack rises. The handshake closes when that ack falls.
// A per-phase watchdog raises a sticky err_to but never abandons the handshake,
// because the far side may still be mid-capture.
module ldl_cdc_hs_src #(
   parameter int DW         = 32,
   parameter int SYNC_DELAY = 2,
   parameter int TO_CYCLES  = 1024,
   parameter int CNT_W      = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic [DW-1:0] xdata,
   output logic          req,
   input  logic          ack_async,
   output logic          done,
   output logic          busy,
   output logic          err_to,
   input  logic          err_clr
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_ACK = 2'd1,
      S_WAIT_REL = 2'd2
   } state_e;

   localparam bit               TO_EN   = (TO_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TO_CYCLES);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TO_CYCLES > 0) ? (TO_CYCLES - 1) : 0);

   state_e                state_q;
   logic                  req_q;
   logic [DW-1:0]         xdata_q;
   logic                  done_q;
   logic                  err_to_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CNT_W-1:0]      cnt_d;
   logic [SYNC_DELAY-1:0] ack_sync_q;
   logic                  ack_s;
   logic                  stay;
   logic                  to_hit;

   // ack synchronizer: plain shift chain, ack_s is the oldest stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_sync_q <= '0;
      end else begin
         ack_sync_q <= {ack_sync_q[SYNC_DELAY-2:0], ack_async};
      end
   end

   // status decode and watchdog next-state, all derived from registers only
   always_comb begin
      ack_s    = ack_sync_q[SYNC_DELAY-1];
      busy     = (state_q != S_IDLE);
      in_ready = (state_q == S_IDLE) && !ack_s;
      // stay: a waiting phase that does not resolve this cycle
      stay     = ((state_q == S_WAIT_ACK) && !ack_s) ||
                 ((state_q == S_WAIT_REL) &&  ack_s);
      to_hit   = TO_EN && stay && (cnt_q == TO_LAST);
      cnt_d    = cnt_q;
      if (!TO_EN || !stay) begin
         cnt_d = '0;
      end else if (cnt_q != TO_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // handshake FSM with registered req/xdata/done and sticky timeout flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         req_q    <= 1'b0;
         xdata_q  <= '0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         err_to_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         cnt_q  <= cnt_d;
         case (state_q)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  xdata_q <= in_data;
                  req_q   <= 1'b1;
                  state_q <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK: begin
               if (ack_s) begin
                  req_q   <= 1'b0;
                  state_q <= S_WAIT_REL;
               end
            end
            S_WAIT_REL: begin
               if (!ack_s) begin
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
         // a fresh timeout beats a simultaneous clear
         if (to_hit) begin
            err_to_q <= 1'b1;
         end else if (err_clr) begin
            err_to_q <= 1'b0;
         end
      end
   end

   assign req    = req_q;
   assign xdata  = xdata_q;
   assign done   = done_q;
   assign err_to = err_to_q;

endmodule

// File: tb/tb_ldl_cdc_hs_src.sv
// Directed bench for ldl_cdc_hs_src: a main instance (SYNC_DELAY=2, TO_CYCLES=16)
// and a second instance (SYNC_DELAY=3, timeout disabled) sharing clock and reset.
module tb_ldl_cdc_hs_src;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic [DW-1:0] xdata;
   logic          req;
   logic          ack_async;
   logic          done;
   logic          busy;
   logic          err_to;
   logic          err_clr;

   logic          loop_en;
   logic          ack_force;
   logic [2:0]    req_dly;

   logic          in_valid3;
   logic [DW-1:0] in_data3;
   logic          in_ready3;
   logic [DW-1:0] xdata3;
   logic          req3;
   logic          ack3;
   logic          done3;
   logic          busy3;
   logic          err_to3;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // far-side model: ack follows req three falling edges later
   always @(negedge clk) begin
      if (!rst_n) req_dly <= 3'b000;
      else        req_dly <= {req_dly[1:0], req};
   end

   assign ack_async = loop_en ? req_dly[2] : ack_force;

   ldl_cdc_hs_src #(.DW(DW), .SYNC_DELAY(2), .TO_CYCLES(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .xdata(xdata), .req(req), .ack_async(ack_async),
      .done(done), .busy(busy), .err_to(err_to), .err_clr(err_clr)
   );

   ldl_cdc_hs_src #(.DW(DW), .SYNC_DELAY(3), .TO_CYCLES(0), .CNT_W(16)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
      .in_ready(in_ready3), .xdata(xdata3), .req(req3), .ack_async(ack3),
      .done(done3), .busy(busy3), .err_to(err_to3), .err_clr(err_clr)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
      loop_en = 1'b0; ack_force = 1'b0;
      in_valid3 = 1'b0; in_data3 = '0; ack3 = 1'b0;
      repeat (3) tick;
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", req); end
      tests++; if (xdata !== 32'h0) begin fails++; $display("FAIL reset_xdata: got %h want 0", xdata); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (err_to !== 1'b0) begin fails++; $display("FAIL reset_err_to: got %b want 0", err_to); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      tests++; if (req3 !== 1'b0 || busy3 !== 1'b0 || in_ready3 !== 1'b1) begin
         fails++; $display("FAIL reset_dut3: req=%b busy=%b in_ready=%b want 0 0 1", req3, busy3, in_ready3);
      end
      rst_n = 1'b1;
      tick;
   endtask

   task automatic test_single;
      int  req_fall;
      int  done_at;
      int  done_cnt;
      bit  xbad;
      bit  bbad;
      req_fall = -1; done_at = -1; done_cnt = 0; xbad = 1'b0; bbad = 1'b0;
      loop_en = 1'b1;
      in_data = 32'hA5A5_0001;
      in_valid = 1'b1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL single_ready: got %b want 1", in_ready); end
      tick;
      in_valid = 1'b0;
      in_data = 32'hFFFF_FFFF;
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL single_req_rise: got %b want 1", req); end
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", busy); end
      tests++; if (xdata !== 32'hA5A5_0001) begin fails++; $display("FAIL single_xdata: got %h want a5a50001", xdata); end
      for (int i = 1; i <= 30; i++) begin
         tick;
         if (req_fall < 0 && req === 1'b0) req_fall = i;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = i;
         end
         if (done_at < 0 && busy !== 1'b1) bbad = 1'b1;
         if (xdata !== 32'hA5A5_0001) xbad = 1'b1;
      end
      // ack reaches ack_s after edge 4, so req drops at edge 5; release mirrors it to edge 10
      tests++; if (req_fall !== 5) begin fails++; $display("FAIL single_req_fall_cycle: got %0d want 5", req_fall); end
      tests++; if (done_at !== 10) begin fails++; $display("FAIL single_done_cycle: got %0d want 10", done_at); end
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL single_done_count: got %0d want 1", done_cnt); end
      tests++; if (xbad !== 1'b0) begin fails++; $display("FAIL single_xdata_held: got %b want 0", xbad); end
      tests++; if (bbad !== 1'b0) begin fails++; $display("FAIL single_busy_held: got %b want 0", bbad); end
      tests++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL single_idle_after: busy=%b in_ready=%b want 0 1", busy, in_ready);
      end
   endtask

   task automatic test_back_to_back;
      logic [DW-1:0] got [8];
      int  k;
      int  ndone;
      bit  overlap;
      bit  capbad;
      bit  acc;
      k = 0; ndone = 0; overlap = 1'b0; capbad = 1'b0;
      for (int i = 0; i < 8; i++) got[i] = 32'hFFFF_FFFF;
      loop_en = 1'b1;
      in_data = 32'd0;
      in_valid = 1'b1;
      for (int c = 0; c < 400 && ndone < 8; c++) begin
         acc = in_valid && in_ready;
         tick;
         if (busy === 1'b1 && in_ready === 1'b1) overlap = 1'b1;
         if (acc) begin
            if (xdata !== DW'(k)) capbad = 1'b1;
            k++;
            in_data = DW'(k);
            if (k == 8) in_valid = 1'b0;
         end
         if (done === 1'b1) begin
            if (ndone < 8) got[ndone] = xdata;
            ndone++;
         end
      end
      in_valid = 1'b0;
      tests++; if (ndone !== 8) begin fails++; $display("FAIL b2b_done_count: got %0d want 8", ndone); end
      tests++; if (k !== 8) begin fails++; $display("FAIL b2b_accept_count: got %0d want 8", k); end
      tests++; if (overlap !== 1'b0) begin fails++; $display("FAIL b2b_ready_while_busy: got %b want 0", overlap); end
      tests++; if (capbad !== 1'b0) begin fails++; $display("FAIL b2b_capture: got %b want 0", capbad); end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if (got[i] !== DW'(i)) begin fails++; $display("FAIL b2b_word%0d: got %h want %h", i, got[i], DW'(i)); end
      end
      tests++; if (err_to !== 1'b0) begin fails++; $display("FAIL b2b_no_timeout: got %b want 0", err_to); end
   endtask

   task automatic test_timeout;
      bit seen;
      loop_en = 1'b0;
      ack_force = 1'b0;
      in_data = 32'h3333_0003;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tests++; if (req !== 1'b1) begin fails++; $display("FAIL to_req_rise: got %b want 1", req); end
      repeat (15) tick;
      tests++; if (err_to !== 1'b0) begin fails++; $display("FAIL to_early_15: got %b want 0", err_to); end
      tick;
      tests++; if (err_to !== 1'b1) begin fails++; $display("FAIL to_set_16: got %b want 1", err_to); end
      repeat (10) tick;
      tests++; if (err_to !== 1'b1 || req !== 1'b1 || busy !== 1'b1) begin
         fails++; $display("FAIL to_keeps_waiting: err_to=%b req=%b busy=%b want 1 1 1", err_to, req, busy);
      end
      ack_force = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick;
         if (req === 1'b0) seen = 1'b1;
      end
      tests++; if (seen !== 1'b1) begin fails++; $display("FAIL to_req_release: got %b want 1", seen); end
      ack_force = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         tick;
         if (done === 1'b1) seen = 1'b1;
      end
      tests++; if (seen !== 1'b1) begin fails++; $display("FAIL to_done_after_release: got %b want 1", seen); end
      tests++; if (err_to !== 1'b1) begin fails++; $display("FAIL to_sticky: got %b want 1", err_to); end
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      tests++; if (err_to !== 1'b0) begin fails++; $display("FAIL to_clear: got %b want 0", err_to); end
      tests++; if (xdata !== 32'h3333_0003) begin fails++; $display("FAIL to_xdata: got %h want 33330003", xdata); end
   endtask

   task automatic test_spurious_ack;
      bit sbad;
      sbad = 1'b0;
      loop_en = 1'b0;
      ack_force = 1'b1;
      tick;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL spur_ready_edge1: got %b want 1", in_ready); end
      tick;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL spur_ready_edge2: got %b want 0", in_ready); end
      in_data = 32'hDEAD_BEEF;
      in_valid = 1'b1;
      repeat (6) begin
         tick;
         if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0 || xdata !== 32'h3333_0003) sbad = 1'b1;
      end
      tests++; if (sbad !== 1'b0) begin fails++; $display("FAIL spur_ignored: got %b want 0", sbad); end
      in_valid = 1'b0;
      ack_force = 1'b0;
      tick;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL spur_drop_edge1: got %b want 0", in_ready); end
      tick;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL spur_drop_edge2: got %b want 1", in_ready); end
   endtask

   task automatic test_reset_mid;
      loop_en = 1'b0;
      ack_force = 1'b0;
      in_data = 32'h5555_AAAA;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      repeat (20) tick;
      tests++; if (req !== 1'b1 || err_to !== 1'b1) begin
         fails++; $display("FAIL rstmid_precond: req=%b err_to=%b want 1 1", req, err_to);
      end
      rst_n = 1'b0;
      tick;
      tests++; if (req !== 1'b0) begin fails++; $display("FAIL rstmid_req: got %b want 0", req); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      tests++; if (xdata !== 32'h0) begin fails++; $display("FAIL rstmid_xdata: got %h want 0", xdata); end
      tests++; if (err_to !== 1'b0) begin fails++; $display("FAIL rstmid_err_to: got %b want 0", err_to); end
      rst_n = 1'b1;
      tick;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_after: got %b want 1", in_ready); end
   endtask

   task automatic test_sync_depth;
      ack3 = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick;
         tests++;
         if (in_ready3 !== (e < 3)) begin
            fails++; $display("FAIL sync3_rise_edge%0d: in_ready got %b want %b", e, in_ready3, (e < 3));
         end
      end
      ack3 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick;
         tests++;
         if (in_ready3 !== (e >= 3)) begin
            fails++; $display("FAIL sync3_fall_edge%0d: in_ready got %b want %b", e, in_ready3, (e >= 3));
         end
      end
      in_data3 = 32'h0000_6666;
      in_valid3 = 1'b1;
      tick;
      in_valid3 = 1'b0;
      tests++; if (req3 !== 1'b1 || xdata3 !== 32'h0000_6666) begin
         fails++; $display("FAIL sync3_accept: req=%b xdata=%h want 1 00006666", req3, xdata3);
      end
      repeat (40) tick;
      tests++; if (err_to3 !== 1'b0 || req3 !== 1'b1) begin
         fails++; $display("FAIL sync3_no_timeout: err_to=%b req=%b want 0 1", err_to3, req3);
      end
      // ack_s is valid after edge 3, the FSM acts on edge 4
      ack3 = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick;
         tests++;
         if (req3 !== (e < 4)) begin
            fails++; $display("FAIL sync3_req_edge%0d: got %b want %b", e, req3, (e < 4));
         end
      end
      ack3 = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         tick;
         tests++;
         if (done3 !== (e == 4)) begin
            fails++; $display("FAIL sync3_done_edge%0d: got %b want %b", e, done3, (e == 4));
         end
      end
      tests++; if (busy3 !== 1'b0) begin fails++; $display("FAIL sync3_idle: got %b want 0", busy3); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_timeout;
      test_spurious_ack;
      test_reset_mid;
      test_sync_depth;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
